// File: rtl/imm_pkg.sv
// imm_pkg: definitions shared by the control unit and the immediate stage.
//   INSTR_WIDTH  - instruction word width
//   imm_src_e    - 3-bit immediate format select (legacy 2-bit codes zero-extend)
//   skid_state_e - occupancy of the 2-entry output skid buffer
package imm_pkg;

  localparam int unsigned INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    IMM_ZERO = 3'b000,
    IMM_I    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_U    = 3'b100,
    IMM_J    = 3'b101,
    IMM_Z    = 3'b110,
    IMM_RSVD = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational RV32I immediate extraction and extension.
//   instr_i   - instruction word
//   imm_src_i - format select (imm_src_e encoding)
//   imm_o     - immediate extended to DATA_WIDTH
//   err_o     - reserved format code used
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [2:0]             imm_src_i,
  output logic [DATA_WIDTH-1:0]  imm_o,
  output logic                   err_o
);

  imm_src_e         src;
  logic [31:0]      raw;
  logic             unused_opcode;

  assign src           = imm_src_e'(imm_src_i);
  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instr_i[6:0];

  // Each format is first assembled as a 32-bit value whose bit 31 is the
  // extension bit, so a single signed widening covers every DATA_WIDTH.
  always_comb begin
    raw   = '0;
    err_o = 1'b0;
    unique case (src)
      IMM_ZERO: raw = '0;
      IMM_I:    raw = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:    raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:    raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:    raw = {instr_i[31:12], 12'b0};
      IMM_J:    raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};
      IMM_Z:    raw = {27'b0, instr_i[19:15]};
      IMM_RSVD: begin
        raw   = '0;
        err_o = 1'b1;
      end
      default:  raw = '0;
    endcase
  end

  assign imm_o = DATA_WIDTH'($signed(raw));

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a 2-entry skid buffer.
//   clk, rst_n          - clock (rising edge), async active-low reset
//   in_valid/in_ready   - upstream handshake; instr, ImmSrc, in_tag accepted
//   flush               - synchronous squash of all held entries
//   out_valid/out_ready - downstream handshake; ImmOp, out_tag, out_err presented
// in_ready is a function of registered state only.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [2:0]             ImmSrc,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  ImmOp,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_err
);

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_imm_q, skid_imm_q;
  logic [TAG_WIDTH-1:0]  main_tag_q, skid_tag_q;
  logic                  main_err_q, skid_err_q;

  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_err;
  logic                  accept, pop;
  logic                  ld_main_in, ld_main_skid, ld_skid;

  imm_decode #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_decode (
    .instr_i   (instr),
    .imm_src_i (ImmSrc),
    .imm_o     (dec_imm),
    .err_o     (dec_err)
  );

  assign in_ready  = (state_q != SKID_TWO);
  assign out_valid = (state_q != SKID_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            state_d    = SKID_ONE;
            ld_main_in = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && pop) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            state_d = SKID_TWO;
            ld_skid = 1'b1;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (pop) begin
            state_d      = SKID_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_err_q <= 1'b0;
    end else if (ld_main_in) begin
      main_imm_q <= dec_imm;
      main_tag_q <= in_tag;
      main_err_q <= dec_err;
    end else if (ld_main_skid) begin
      main_imm_q <= skid_imm_q;
      main_tag_q <= skid_tag_q;
      main_err_q <= skid_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
    end else if (ld_skid) begin
      skid_imm_q <= dec_imm;
      skid_tag_q <= in_tag;
      skid_err_q <= dec_err;
    end
  end

  assign ImmOp   = main_imm_q;
  assign out_tag = main_tag_q;
  assign out_err = main_err_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  ImmSrc;
  logic [31:0] in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_err;
  logic [31:0] ImmOp, out_tag;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] ImmOp64;
  logic [31:0] out_tag64;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  imm_gen_stage #(.DATA_WIDTH(32), .TAG_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ImmOp(ImmOp),
    .out_tag(out_tag), .out_err(out_err)
  );

  imm_gen_stage #(.DATA_WIDTH(64), .TAG_WIDTH(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .ImmOp(ImmOp64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: extend each field from its own natural width.
  function automatic exp_t ref_entry(input logic [31:0] ins, input logic [2:0] src,
                                     input logic [31:0] tag);
    exp_t e;
    logic [11:0] f12;
    logic [12:0] f13;
    logic [20:0] f21;
    logic [31:0] f32;
    e.tag = tag;
    e.err = 1'b0;
    e.imm = 64'd0;
    case (src)
      3'd1: begin f12 = ins[31:20]; e.imm = 64'($signed(f12)); end
      3'd2: begin f12 = {ins[31:25], ins[11:7]}; e.imm = 64'($signed(f12)); end
      3'd3: begin f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; e.imm = 64'($signed(f13)); end
      3'd4: begin f32 = {ins[31:12], 12'd0}; e.imm = 64'($signed(f32)); end
      3'd5: begin f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; e.imm = 64'($signed(f21)); end
      3'd6: e.imm = 64'(ins[19:15]);
      3'd7: e.err = 1'b1;
      default: e.imm = 64'd0;
    endcase
    return e;
  endfunction

  // Drive one cycle of stimulus and advance the queue model across the edge.
  // Leaves time at posedge+1 with the model matching the post-edge contents.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] tag, input logic ordy, input logic fl);
    bit do_pop, do_acc;
    @(negedge clk);
    in_valid  = v;
    instr     = ins;
    ImmSrc    = src;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    do_pop = (exp_q.size() > 0) && ordy;
    do_acc = (exp_q.size() < 2) && v;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_acc) exp_q.push_back(ref_entry(ins, src, tag));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 32'd0, 3'd0, 32'd0, ordy, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 0; instr = 0; ImmSrc = 0; in_tag = 0; flush = 0; out_ready = 0;
    #12;
    total++;
    if (out_valid !== 1'b0 || ImmOp !== 32'd0 || out_tag !== 32'd0 || out_err !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: got v=%b imm=%h tag=%h err=%b, want all 0",
                      out_valid, ImmOp, out_tag, out_err);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_vectors;
    logic [31:0] vi [6] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
                            32'h123450B7, 32'hFFDFF06F, 32'h000FD073};
    logic [2:0]  vs [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [31:0] ve [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                            32'h12345000, 32'hFFFFFFFC, 32'h0000001F};
    logic [63:0] ve64 [6] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFF8,
                              64'h00000000_12345000, 64'hFFFFFFFF_FFFFFFFC, 64'h00000000_0000001F};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vi[i], vs[i], 32'(100 + i), 1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b1 || ImmOp !== ve[i] || out_tag !== 32'(100 + i)) begin
        bad++; $display("FAIL vector%0d: got v=%b imm=%h tag=%0d want v=1 imm=%h tag=%0d",
                        i, out_valid, ImmOp, out_tag, ve[i], 100 + i);
      end
      total++;
      if (ImmOp64 !== ve64[i]) begin
        bad++; $display("FAIL vector64_%0d: got %h want %h", i, ImmOp64, ve64[i]);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_backpressure;
    logic [31:0] ia = 32'h00500093, ib = 32'hFFB00093, ic = 32'h7FF00093;
    cycle(1'b1, ia, 3'd1, 32'd1, 1'b0, 1'b0);
    cycle(1'b1, ib, 3'd1, 32'd2, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, ic, 3'd1, 32'd3, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || ImmOp !== 32'd5 || out_tag !== 32'd1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_stall%0d: got v=%b imm=%h tag=%0d rdy=%b want v=1 imm=5 tag=1 rdy=0",
                        k, out_valid, ImmOp, out_tag, in_ready);
      end
    end
    // Release: A pops, B then C must follow on consecutive cycles.
    cycle(1'b1, ic, 3'd1, 32'd3, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_tag !== 32'd2 || ImmOp !== 32'hFFFFFFFB) begin
      bad++; $display("FAIL bp_B: got v=%b tag=%0d imm=%h want v=1 tag=2 imm=fffffffb",
                      out_valid, out_tag, ImmOp);
    end
    cycle(1'b1, ic, 3'd1, 32'd3, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_tag !== 32'd3 || ImmOp !== 32'h000007FF) begin
      bad++; $display("FAIL bp_C: got v=%b tag=%0d imm=%h want v=1 tag=3 imm=7ff",
                      out_valid, out_tag, ImmOp);
    end
    idle(1'b1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_streaming;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 32'h12345000 + 32'(i << 12), 3'd4, 32'(200 + i), 1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b1 || out_tag !== 32'(200 + i) || in_ready !== 1'b1) begin
        bad++; $display("FAIL stream%0d: got v=%b tag=%0d rdy=%b want v=1 tag=%0d rdy=1",
                        i, out_valid, out_tag, in_ready, 200 + i);
      end
    end
    idle(1'b1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    cycle(1'b1, 32'hFFF00093, 3'd1, 32'd301, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFF00093, 3'd1, 32'd302, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFF00093, 3'd1, 32'd303, 1'b1, 1'b1);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_state: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL flush_ghost%0d: out_valid got %b tag=%0d want 0", k, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_reserved;
    cycle(1'b1, 32'hFFFFFFFF, 3'd7, 32'd400, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || ImmOp !== 32'd0 || ImmOp64 !== 64'd0) begin
      bad++; $display("FAIL reserved: got v=%b err=%b imm=%h imm64=%h want v=1 err=1 imm=0",
                      out_valid, out_err, ImmOp, ImmOp64);
    end
    idle(1'b1);
  endtask

  task automatic test_reset_midstream;
    cycle(1'b1, 32'hFFF00093, 3'd1, 32'd501, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE20AE23, 3'd2, 32'd502, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || ImmOp !== 32'd0 || out_tag !== 32'd0 || out_err !== 1'b0 ||
        in_ready !== 1'b1 || ImmOp64 !== 64'd0) begin
      bad++; $display("FAIL reset_mid: got v=%b imm=%h tag=%h err=%b rdy=%b want v=0 all 0 rdy=1",
                      out_valid, ImmOp, out_tag, out_err, in_ready);
    end
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_mid_ghost: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_random;
    int errs = 0;
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) != 0), $urandom_range(0, 19) == 0);
      total++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_ctl@%0d: got v=%b rdy=%b want v=%b rdy=%b",
                                n, out_valid, in_ready, exp_q.size() > 0, exp_q.size() < 2);
      end else if (exp_q.size() > 0) begin
        total++;
        if (ImmOp !== exp_q[0].imm[31:0] || out_tag !== exp_q[0].tag || out_err !== exp_q[0].err ||
            ImmOp64 !== exp_q[0].imm) begin
          bad++; errs++;
          if (errs < 10) $display("FAIL rand_data@%0d: got imm=%h imm64=%h tag=%h err=%b want imm64=%h tag=%h err=%b",
                                  n, ImmOp, ImmOp64, out_tag, out_err,
                                  exp_q[0].imm, exp_q[0].tag, exp_q[0].err);
        end
      end
    end
    idle(1'b1);
    idle(1'b1);
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_streaming;
    test_flush;
    test_reserved;
    test_random;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the decode path. It replaces the two-format combinational extender with full RV32I immediate coverage: I, S, B, U and J formats, plus CSR zimm. Results are sign- or zero-extended to `DATA_WIDTH`, so 64-bit datapaths are supported. The stage sits between fetch/decode and the register-read/ALU operand mux. A 2-entry skid buffer with a valid/ready handshake gives full throughput under backpressure, and a flush input squashes in-flight entries on redirect.

## Interface
- `DATA_WIDTH`, 32: width of `ImmOp`; legal values are ≥ 32.
- `TAG_WIDTH`, 32: width of the sideband tag (PC, rd, etc.) carried alongside each immediate.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; a transfer occurs when `in_valid && in_ready`.
- `instr`  in  32  instruction word.
- `ImmSrc`  in  3  immediate format select (encoding under Operation).
- `in_tag`  in  `TAG_WIDTH`  sideband, passed through unchanged.
- `flush`  in  1  synchronous squash of all held entries.
- `out_valid`  out  1  `ImmOp`/`out_tag`/`out_err` are valid.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `ImmOp`  out  `DATA_WIDTH`  extended immediate.
- `out_tag`  out  `TAG_WIDTH`  tag of the entry being presented.
- `out_err`  out  1  entry used a reserved `ImmSrc` code.

## Operation
- `ImmSrc` encoding (the legacy 2-bit codes zero-extend and keep their meaning):
  - 000 ZERO: `ImmOp` = 0.
  - 001 I: sext(`instr[31:20]`).
  - 010 S: sext({`instr[31:25]`, `instr[11:7]`}).
  - 011 B: sext({`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}).
  - 100 U: sext({`instr[31:12]`, 12'b0}).
  - 101 J: sext({`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}).
  - 110 Z: zero-extended `instr[19:15]`.
  - 111 reserved: `ImmOp` = 0 and `out_err` = 1.
- Sign extension replicates `instr[31]` up to bit `DATA_WIDTH-1`. U-type results are sign-extended at `DATA_WIDTH` = 64, matching RV64 LUI.
- The immediate is computed combinationally from the accepted input and captured into the stage register; nothing is recomputed at the output.
- Skid buffer states:
  - EMPTY: no entry.
  - ONE: main register valid.
  - TWO: main and skid registers both valid.
- `in_ready` = (state != TWO).
- EMPTY → ONE on accept.
- ONE → EMPTY on pop with no accept.
- ONE → ONE on simultaneous pop and accept; the main register reloads.
- ONE → TWO on accept with no pop; the new entry goes to skid.
- TWO → ONE on pop; skid moves to main.
- TWO takes no accept, since `in_ready` = 0.
- Ordering is strictly FIFO, and output data is stable while `out_valid && !out_ready`.
- `flush`: next state is EMPTY. Any same-cycle accept is discarded, and so is any same-cycle pop. Flush has priority over every other event.

## Timing
- Reset (asserted `rst_n` = 0, effective immediately):
  - state = EMPTY.
  - `out_valid` = 0, `ImmOp` = 0, `out_tag` = 0, `out_err` = 0.
  - `in_ready` = 1.
- Reset mid-operation drops all held entries without producing any output.
- Latency: accepted at edge N → `out_valid` = 1 after edge N, presented in cycle N+1.
- Throughput is 1 entry/cycle with `out_ready` held high. `in_ready` depends only on registered state, with no combinational path from `out_ready`.
- After `flush` at edge N, `out_valid` = 0 and `in_ready` = 1 in cycle N+1.
- While `out_valid` = 0, `ImmOp`, `out_tag` and `out_err` hold their last values; they are don't-care to consumers.

## Structure
- Package `imm_pkg`:
  - `imm_src_e` enum (the 3-bit codes above).
  - skid state enum.
  - `INSTR_WIDTH` = 32.
  - shared by the control unit and this block.
- Sub-module `imm_decode`: purely combinational. Takes `instr`, `ImmSrc` and `DATA_WIDTH`, and produces {`ImmOp`, `err`}.
- Top `imm_gen_stage` holds the skid buffer FSM and registers.

## Test plan
- I/S/B, `DATA_WIDTH` = 32:
  - `0xFFF00093`/001 → `ImmOp` `0xFFFFFFFF`.
  - `0xFE20AE23`/010 → `0xFFFFFFFC`.
  - `0xFE000CE3`/011 → `0xFFFFFFF8`.
- U/J/Z:
  - `0x123450B7`/100 → `0x12345000`.
  - `0xFFDFF06F`/101 → `0xFFFFFFFC`.
  - `0x000FD073`/110 → `0x0000001F`.
  - `DATA_WIDTH` = 64, `0xFFF00093`/001 → all ones.
- Backpressure: hold `out_ready` = 0 and push A, B, C. A and B are accepted, `in_ready` = 0 in the cycle after B, and C is held upstream. Raise `out_ready` → A, B, C emerge in order on consecutive cycles with data stable while stalled.
- Streaming: `in_valid` = `out_ready` = 1 for 8 entries → 8 outputs on 8 consecutive cycles, first output 1 cycle after the first accept.
- Flush in TWO with a simultaneous `in_valid`: next cycle `out_valid` = 0, `in_ready` = 1, and the flushed entries and the simultaneous input never appear.
- Reserved code 111 → `out_err` = 1, `ImmOp` = 0. Assert `rst_n` = 0 mid-stream (state TWO) → `out_valid` drops immediately and all outputs read 0.
